sine_nco_reader: RTL and testbench

// - Phase-accumulator front end for the JERRY sine table ROM: steps a 32-bit phase, issues one ROM read per sample,

---
 rtl/sine_nco_reader_pkg.sv | 14 +
 rtl/sine_nco_reader_if.sv | 25 ++
 rtl/sine_nco_reader_fifo.sv | 54 +++++
 rtl/sine_nco_reader.sv | 114 +++++++++++
 tb/tb_sine_nco_reader.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sine_nco_reader_pkg.sv
// sine_nco_reader_pkg: ROM geometry constants and
// reader FSM state encoding shared by the NCO slice.
package sine_nco_reader_pkg;

  localparam int ROM_ADDR_W = 10;
  localparam int ROM_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } nco_state_e;

endpackage

// File: rtl/sine_nco_reader_if.sv
// sine_nco_reader_if: valid/ready sample stream.
// master: smp_data/smp_valid out, smp_ready in.
interface sine_nco_reader_if
  import sine_nco_reader_pkg::*;
#(
  parameter int DATA_W = ROM_DATA_W
) ();

  logic [DATA_W-1:0] smp_data;
  logic              smp_valid;
  logic              smp_ready;

  modport master (
    output smp_data,
    output smp_valid,
    input  smp_ready
  );

  modport slave (
    input  smp_data,
    input  smp_valid,
    output smp_ready
  );

endinterface

// File: rtl/sine_nco_reader_fifo.sv
// nco_smp_fifo: DEPTH x DATA_W sync FIFO, head-of-queue
// output. Ports: push/push_data, pop, head, count.
module nco_smp_fifo #(
  parameter  int DEPTH  = 2,
  parameter  int DATA_W = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != '0);
  // a full buffer may still take a word when the head leaves
  assign do_push = push &&
    ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sine_nco_reader.sv
// sine_nco_reader: phase accumulator + sine ROM read FSM,
// ROM cs/a/z port, sample stream out (smp), sticky rd_err.
module sine_nco_reader
  import sine_nco_reader_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int ADDR_W    = ROM_ADDR_W,
  parameter int DATA_W    = ROM_DATA_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic              sys_clk,
  input  logic              resetl,
  input  logic              enable,
  input  logic              phase_ld,
  input  logic [ACC_W-1:0]  phase_init,
  input  logic [ACC_W-1:0]  phase_inc_in,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [DATA_W-1:0] rom_z,
  input  logic [DATA_W-1:0] rom_z_oe,
  sine_nco_reader_if.master smp,
  output logic              rd_err
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  nco_state_e       state_q;
  nco_state_e       state_d;
  logic [ACC_W-1:0] phase_q;
  logic [ACC_W-1:0] inc_q;
  logic [CNT_W-1:0] buf_cnt;
  logic [CNT_W:0]   occ;
  logic             in_flight;
  logic             credit;
  logic             issue;
  logic             capture;
  logic             pop;
  logic             oe_bad;

  assign in_flight = (state_q != ST_IDLE);
  // reserve a slot for the read still on the ROM bus
  assign occ    = {1'b0, buf_cnt}
                + (CNT_W+1)'(in_flight);
  assign credit = occ < (CNT_W+1)'(BUF_DEPTH);
  assign issue   = (state_q == ST_ISSUE);
  assign capture = (state_q == ST_WAIT);
  assign oe_bad  = (rom_z_oe != '1);

  assign rom_cs = ~issue;
  assign rom_a  = phase_q[ACC_W-1 -: ADDR_W];

  assign smp.smp_valid = (buf_cnt != '0);
  assign pop = smp.smp_valid && smp.smp_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && credit) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d = (enable && credit) ? ST_ISSUE
                                     : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // a load on the issue edge wins over the step
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      phase_q <= '0;
      inc_q   <= '0;
    end else if (phase_ld) begin
      phase_q <= phase_init;
      inc_q   <= phase_inc_in;
    end else if (issue) begin
      phase_q <= phase_q + inc_q;
    end
  end

  // a fault captured on the load edge is kept
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      rd_err <= 1'b0;
    end else begin
      rd_err <= (rd_err & ~phase_ld)
              | (capture & oe_bad);
    end
  end

  nco_smp_fifo #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (resetl),
    .push      (capture),
    .push_data (rom_z),
    .pop       (pop),
    .head      (smp.smp_data),
    .count     (buf_cnt)
  );

endmodule

// File: tb/tb_sine_nco_reader.sv
// tb_sine_nco_reader: directed + random stimulus against
// a queue-based model of the phase reader and its buffer.
module tb_sine_nco_reader;

  localparam int BUF_DEPTH = 2;

  logic        sys_clk      = 1'b0;
  logic        resetl       = 1'b0;
  logic        enable       = 1'b0;
  logic        phase_ld     = 1'b0;
  logic [31:0] phase_init   = '0;
  logic [31:0] phase_inc_in = '0;
  logic        rom_cs;
  logic [9:0]  rom_a;
  logic [15:0] rom_z        = '0;
  logic [15:0] rom_z_oe;
  logic [15:0] oe_drv       = 16'hFFFF;
  logic        rd_err;

  sine_nco_reader_if #(.DATA_W(16)) smp ();

  sine_nco_reader #(
    .ACC_W     (32),
    .ADDR_W    (10),
    .DATA_W    (16),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .sys_clk      (sys_clk),
    .resetl       (resetl),
    .enable       (enable),
    .phase_ld     (phase_ld),
    .phase_init   (phase_init),
    .phase_inc_in (phase_inc_in),
    .rom_cs       (rom_cs),
    .rom_a        (rom_a),
    .rom_z        (rom_z),
    .rom_z_oe     (rom_z_oe),
    .smp          (smp),
    .rd_err       (rd_err)
  );

  always #5 sys_clk = ~sys_clk;

  // behavioural ROM, one cycle read latency
  logic [15:0] rom_mem [1024];
  logic        cs_s = 1'b1;
  logic [9:0]  a_s  = '0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom_mem[i] = 16'(i) ^ 16'hA5A5;
    end
  end

  assign rom_z_oe = oe_drv;

  always @(negedge sys_clk) begin
    cs_s = rom_cs;
    a_s  = rom_a;
  end

  always @(posedge sys_clk) begin
    if (!cs_s) rom_z <= rom_mem[a_s];
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // reference model, advanced once per cycle at negedge
  logic [31:0] m_phase  = '0;
  logic [31:0] m_inc    = '0;
  logic [15:0] m_buf[$];
  logic [15:0] m_pend   = '0;
  logic        m_pend_v = 1'b0;
  logic        m_err    = 1'b0;
  logic        prev_iss = 1'b0;
  logic        bad;
  int          cyc      = 0;
  int          first_cs = -1;
  int          first_v  = -1;
  logic [9:0]  addr_log[$];
  logic [15:0] data_log[$];

  always @(negedge sys_clk) begin
    cyc++;
    if (!resetl) begin
      chk("rst_cs", 32'(rom_cs), 32'd1);
      chk("rst_a", 32'(rom_a), 32'd0);
      chk("rst_valid", 32'(smp.smp_valid), 32'd0);
      chk("rst_data", 32'(smp.smp_data), 32'd0);
      chk("rst_err", 32'(rd_err), 32'd0);
      m_buf.delete();
      m_phase  = '0;
      m_inc    = '0;
      m_pend_v = 1'b0;
      m_err    = 1'b0;
      prev_iss = 1'b0;
    end else begin
      chk("valid", 32'(smp.smp_valid),
          32'(m_buf.size() != 0));
      if (m_buf.size() != 0) begin
        chk("data", 32'(smp.smp_data), 32'(m_buf[0]));
      end
      if (smp.smp_valid && smp.smp_ready) begin
        data_log.push_back(smp.smp_data);
        if (m_buf.size() != 0) void'(m_buf.pop_front());
      end
      chk("rd_err", 32'(rd_err), 32'(m_err));
      bad = m_pend_v && (rom_z_oe != 16'hFFFF);
      m_err = (phase_ld ? 1'b0 : m_err) | bad;
      if (m_pend_v) begin
        m_buf.push_back(m_pend);
        m_pend_v = 1'b0;
        chk("no_overflow",
            32'(m_buf.size() <= BUF_DEPTH), 32'd1);
      end
      if (!rom_cs) begin
        chk("issue_gap", 32'(prev_iss), 32'd0);
        chk("rom_a", 32'(rom_a), 32'(m_phase[31:22]));
        addr_log.push_back(rom_a);
        m_pend   = 16'(m_phase[31:22]) ^ 16'hA5A5;
        m_pend_v = 1'b1;
        if (first_cs < 0) first_cs = cyc;
      end
      if (smp.smp_valid && first_v < 0) first_v = cyc;
      prev_iss = !rom_cs;
      if (phase_ld) begin
        m_phase = phase_init;
        m_inc   = phase_inc_in;
      end else if (!rom_cs) begin
        m_phase = m_phase + m_inc;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (rom_cs !== 1'b0 && n < 12) begin
      step(1);
      n++;
    end
    chk("issue_timeout", 32'(rom_cs), 32'd0);
  endtask

  task automatic clr_logs();
    addr_log.delete();
    data_log.delete();
    first_cs = -1;
    first_v  = -1;
  endtask

  // load phase/inc with a one-cycle strobe, run flag set
  task automatic load(logic [31:0] init,
                      logic [31:0] inc, logic en);
    phase_init   = init;
    phase_inc_in = inc;
    phase_ld     = 1'b1;
    enable       = en;
    step(1);
    phase_ld = 1'b0;
  endtask

  function automatic logic [31:0] at_a(int i);
    return (i < addr_log.size()) ? 32'(addr_log[i])
                                 : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] at_d(int i);
    return (i < data_log.size()) ? 32'(data_log[i])
                                 : 32'hFFFF_FFFF;
  endfunction

  logic [15:0] exp_d [4];

  initial begin
    smp.smp_ready = 1'b1;
    step(3);
    resetl = 1'b1;
    step(50);
    chk("idle_cs", 32'(rom_cs), 32'd1);
    chk("idle_a", 32'(rom_a), 32'd0);
    chk("idle_valid", 32'(smp.smp_valid), 32'd0);
    chk("idle_data", 32'(smp.smp_data), 32'd0);
    chk("idle_err", 32'(rd_err), 32'd0);
    chk("idle_noread", 32'(addr_log.size()), 32'd0);

    // ascending sweep, enable dropped during last WAIT
    clr_logs();
    load(32'h0, 32'h0040_0000, 1'b1);
    step(7);
    enable = 1'b0;
    step(6);
    exp_d = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};
    chk("seq_n", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("seq_a", at_a(i), 32'(i));
      chk("seq_d", at_d(i), 32'(exp_d[i]));
    end
    chk("latency", 32'(first_v - first_cs), 32'd2);

    // descending sweep across address zero
    clr_logs();
    load(32'h0040_0000, 32'hFFC0_0000, 1'b1);
    step(7);
    enable = 1'b0;
    step(6);
    exp_d = '{16'hA5A4, 16'hA5A5, 16'hA65A, 16'hA65B};
    chk("wrap_a0", at_a(0), 32'd1);
    chk("wrap_a1", at_a(1), 32'd0);
    chk("wrap_a2", at_a(2), 32'd1023);
    chk("wrap_a3", at_a(3), 32'd1022);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_d", at_d(i), 32'(exp_d[i]));
    end

    // zero increment holds the address
    clr_logs();
    load(32'h0040_0000, 32'h0, 1'b1);
    step(7);
    enable = 1'b0;
    step(6);
    chk("const_n", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("const_a", at_a(i), 32'd1);
    end

    // downstream stall fills the buffer then stops reads
    clr_logs();
    smp.smp_ready = 1'b0;
    load(32'h0, 32'h0040_0000, 1'b1);
    step(19);
    chk("stall_valid", 32'(smp.smp_valid), 32'd1);
    chk("stall_cs", 32'(rom_cs), 32'd1);
    chk("stall_reads", 32'(addr_log.size()),
        32'(BUF_DEPTH));
    step(1);
    chk("stall_cs2", 32'(rom_cs), 32'd1);
    smp.smp_ready = 1'b1;
    step(10);
    enable = 1'b0;
    step(8);
    chk("stall_no_loss", 32'(data_log.size()),
        32'(addr_log.size()));
    chk("stall_more", 32'(data_log.size() > 3), 32'd1);
    for (int i = 0; i < data_log.size(); i++) begin
      chk("stall_d", at_d(i), 32'(16'(i) ^ 16'hA5A5));
    end

    // reload while a read is on the bus
    clr_logs();
    load(32'h0, 32'h0040_0000, 1'b1);
    wait_issue();
    step(1);
    phase_init   = 32'h8000_0000;
    phase_inc_in = 32'h0040_0000;
    phase_ld     = 1'b1;
    step(1);
    phase_ld = 1'b0;
    step(4);
    enable = 1'b0;
    step(6);
    chk("ld_a0", at_a(0), 32'd0);
    chk("ld_a1", at_a(1), 32'd512);
    chk("ld_d0", at_d(0), 32'h0000_A5A5);
    chk("ld_d1", at_d(1), 32'h0000_A7A5);

    // enable fault on a single capture
    load(32'h0, 32'h0040_0000, 1'b1);
    wait_issue();
    step(1);
    oe_drv = 16'h00FF;
    step(1);
    oe_drv = 16'hFFFF;
    chk("err_set", 32'(rd_err), 32'd1);
    step(5);
    chk("err_sticky", 32'(rd_err), 32'd1);
    enable = 1'b0;
    step(6);
    chk("err_hold", 32'(rd_err), 32'd1);
    load(32'h0, 32'h0, 1'b0);
    chk("err_clr", 32'(rd_err), 32'd0);

    // reset pulse during WAIT with a sample buffered
    smp.smp_ready = 1'b0;
    load(32'h0, 32'h0040_0000, 1'b1);
    wait_issue();
    step(3);
    chk("pre_rst_valid", 32'(smp.smp_valid), 32'd1);
    resetl = 1'b0;
    enable = 1'b0;
    step(1);
    resetl = 1'b1;
    chk("rst_mid_valid", 32'(smp.smp_valid), 32'd0);
    chk("rst_mid_cs", 32'(rom_cs), 32'd1);
    step(5);
    chk("rst_mid_empty", 32'(smp.smp_valid), 32'd0);
    chk("rst_mid_err", 32'(rd_err), 32'd0);
    smp.smp_ready = 1'b1;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      smp.smp_ready = ($urandom_range(0, 3) != 0);
      enable        = ($urandom_range(0, 7) != 0);
      phase_ld      = ($urandom_range(0, 15) == 0);
      phase_init    = $urandom;
      phase_inc_in  = $urandom;
      oe_drv = ($urandom_range(0, 29) == 0)
             ? 16'($urandom) : 16'hFFFF;
      step(1);
    end
    phase_ld      = 1'b0;
    enable        = 1'b0;
    oe_drv        = 16'hFFFF;
    smp.smp_ready = 1'b1;
    step(10);
    chk("drain_valid", 32'(smp.smp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
